// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory access path: access-size
// encodings, the load/store FSM state type and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } dm_state_t;

  // True when the access cannot be issued as a single aligned transaction:
  // odd halfword, non-word-aligned word, or the illegal size encoding.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for a 32-bit little-endian bus. Store side replicates the
// right-justified data into every lane and raises the enables of the lanes the
// access covers; load side picks the addressed field and sign/zero extends it.
// Purely combinational so the fetch side can share it.
module mem_lane
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  st_byteen,
  output logic [31:0] st_wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane enables, replicated store data and extended load field per access size.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned and nothing is inferred as a latch.
    st_byteen = 4'b0000;
    st_wdata  = st_data;
    ld_data   = ld_word;
    byte_sel  = ld_word[{offset, 3'b000} +: 8];
    half_sel  = ld_word[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        st_byteen = 4'b0001 << offset;
        st_wdata  = {4{st_data[7:0]}};
        ld_data   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        st_byteen = offset[1] ? 4'b1100 : 4'b0011;
        st_wdata  = {2{st_data[15:0]}};
        ld_data   = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        st_byteen = 4'b1111;
      end
      default: begin
        st_byteen = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dm_bus_master.sv
// M-stage load/store initiator. Registers one request, drives a word-aligned
// byte-enabled transaction until the memory acknowledges (or a wait limit
// expires), then returns a one-cycle response with extended load data.
module dm_bus_master
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        bus_req,
  input  logic        bus_ack,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_inst_addr
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  dm_state_t state, state_next;

  logic          we_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   pc_q;
  logic [CW-1:0] wait_cnt;
  logic          err_q;
  logic [31:0]   rdata_q;

  logic          accept;
  logic          bad_req;
  logic          wait_expired;
  logic [3:0]    lane_byteen;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_ld;

  assign accept       = (state == ST_IDLE) && req_valid;
  assign bad_req      = misaligned(req_size, req_addr[1:0]);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // Lane logic always works from the registered request, so the bus is stable
  // for the whole transaction regardless of what the pipeline does meanwhile.
  mem_lane u_lane (
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (signed_q),
    .st_data   (wdata_q),
    .ld_word   (m_data_rdata),
    .st_byteen (lane_byteen),
    .st_wdata  (lane_wdata),
    .ld_data   (lane_ld)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and state-decoded outputs; byteen gated by BUS so a reset,
  // error or idle cycle can never write memory.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    bus_req       = 1'b0;
    rsp_valid     = 1'b0;
    m_data_byteen = 4'b0000;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = bad_req ? ST_RESP : ST_BUS;
      end
      ST_BUS: begin
        bus_req       = 1'b1;
        m_data_byteen = we_q ? lane_byteen : 4'b0000;
        if (bus_ack || wait_expired) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counting and response formation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      pc_q     <= req_pc;
      wait_cnt <= '0;
      err_q    <= bad_req;
      rdata_q  <= '0;
    end else if (state == ST_BUS) begin
      if (bus_ack) begin
        rdata_q <= we_q ? 32'h0 : lane_ld;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_expired) err_q <= 1'b1;
      end
    end
  end

  assign stall        = req_valid & ~rsp_valid;
  assign rsp_err      = err_q;
  assign rsp_rdata    = rdata_q;
  assign m_data_addr  = {addr_q[31:2], 2'b00};
  assign m_data_wdata = lane_wdata;
  assign m_inst_addr  = pc_q;

endmodule

// File: tb/tb_dm_bus_master.sv
// Directed bench for dm_bus_master: a small word memory answers the bus after a
// per-request number of wait cycles, the stimulus queues the expected response
// and a monitor compares it whenever rsp_valid is seen.
module tb_dm_bus_master;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        bus_req;
  logic        bus_ack;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;
  logic [31:0] m_inst_addr;

  dm_bus_master #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_signed    (req_signed),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_pc        (req_pc),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .stall         (stall),
    .bus_req       (bus_req),
    .bus_ack       (bus_ack),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_data_rdata  (m_data_rdata),
    .m_inst_addr   (m_inst_addr)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    time         t0;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          ack_wait = 0;
  int          wcnt     = 0;
  logic        stray_ack = 1'b0;
  logic [31:0] mem [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory responder: acks after ack_wait wait cycles (never if negative),
  // applies byte-enabled writes on the ack cycle.
  always @(negedge clk) begin
    if (bus_req) begin
      m_data_rdata = mem[m_data_addr[5:2]];
      if (ack_wait >= 0 && wcnt == ack_wait) begin
        bus_ack = 1'b1;
        for (int b = 0; b < 4; b++)
          if (m_data_byteen[b]) mem[m_data_addr[5:2]][8*b +: 8] = m_data_wdata[8*b +: 8];
      end else begin
        bus_ack = 1'b0;
      end
      wcnt++;
    end else begin
      bus_ack = stray_ack;
      wcnt    = 0;
    end
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (reset && rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 required no response (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
        check("rsp_latency", int'(($time - mon_e.t0) / 10), mon_e.lat);
      end
    end
  end

  // Issue one request at the next falling edge and follow it cycle by cycle
  // until its response; leaves req_valid high on the response cycle.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input int ack_w,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int   lat;
    logic exp_bus;
    exp_t e;
    logic [31:0] pc;
    lat = (ack_w < 0) ? MAX_WAIT + 1 : (exp_err ? 1 : 2 + ack_w);
    pc  = 32'h0040_0000 + addr;
    @(negedge clk);
    ack_wait   = ack_w;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    req_pc     = pc;
    check("req_ready", {31'b0, req_ready}, 32'd1);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = lat;
    e.t0    = $time;
    sb_q.push_back(e);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      exp_bus = (lat > 1) && (i < lat);
      check("stall", {31'b0, stall}, {31'b0, i != lat});
      check("bus_req", {31'b0, bus_req}, {31'b0, exp_bus});
      check("m_data_byteen", {28'b0, m_data_byteen}, {28'b0, exp_bus ? exp_be : 4'b0000});
      if (exp_bus) begin
        check("m_data_addr", m_data_addr, addr & 32'hffff_fffc);
        check("m_inst_addr", m_inst_addr, pc);
        if (we) check("m_data_wdata", m_data_wdata, exp_wd);
      end
    end
    for (int j = 0; j < 20 && !rsp_valid; j++) @(negedge clk);
    if (!rsp_valid) begin
      n_checks++;
      $display("FAIL rsp_wait: got no rsp_valid within bound, required response for addr %h", addr);
    end
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_pc     = '0;
    bus_ack    = 1'b0;
    m_data_rdata = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;

    // Reset values.
    #1;
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_byteen", {28'b0, m_data_byteen}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_m_data_addr", m_data_addr, 32'd0);
    check("rst_m_data_wdata", m_data_wdata, 32'd0);
    check("rst_m_inst_addr", m_inst_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Signed / unsigned halfword loads with 3 wait cycles.
    mem[0] = 32'h8001_1234;
    issue(1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 3, 32'hFFFF_8001, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 3, 32'h0000_8001, 1'b0, 4'b0000, 32'h0);

    // Byte store at top lane, immediate ack.
    issue(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0, 1'b0, 4'b1000, 32'hABAB_ABAB);

    // Misaligned word store: error path, no bus activity.
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0006, 32'hDEAD_BEEF, 0, 32'h0, 1'b1, 4'b0000, 32'h0);

    // Timeout: never acked, bus_req high exactly MAX_WAIT cycles.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, -1, 32'h0, 1'b1, 4'b0000, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    stray_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_ack_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("late_ack_bus_req", {31'b0, bus_req}, 32'd0);
      check("idle_stall", {31'b0, stall}, 32'd0);
    end
    stray_ack = 1'b0;

    // Back-to-back store then byte load of the stored word.
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h1234_5678, 0, 32'h0, 1'b0, 4'b1111, 32'h1234_5678);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'h0, 0, 32'h0000_0056, 1'b0, 4'b0000, 32'h0);

    // Halfword store to upper lanes, then extraction variants.
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_BEEF, 1, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
    issue(1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0, 0, 32'hFFFF_BEEF, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0023, 32'h0, 2, 32'hFFFF_FFBE, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'h0, 0, 32'h0000_0078, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0, 32'hBEEF_5678, 1'b0, 4'b0000, 32'h0);

    // Illegal size and odd halfword are errors.
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0, 0, 32'h0, 1'b1, 4'b0000, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0021, 32'h0, 0, 32'h0, 1'b1, 4'b0000, 32'h0);

    // Ack on the last permitted wait cycle still succeeds.
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, MAX_WAIT - 1, 32'hBEEF_5678, 1'b0, 4'b0000, 32'h0);

    // Async reset in the middle of a store transaction.
    @(negedge clk);
    ack_wait   = -1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h0000_0024;
    req_wdata  = 32'hCAFE_F00D;
    req_pc     = 32'h0040_0100;
    @(negedge clk);
    check("pre_rst_bus_req", {31'b0, bus_req}, 32'd1);
    check("pre_rst_byteen", {28'b0, m_data_byteen}, 32'hF);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("mid_rst_byteen", {28'b0, m_data_byteen}, 32'd0);
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_m_data_addr", m_data_addr, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("post_rst_bus_req", {31'b0, bus_req}, 32'd0);
    end

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
